// File: rtl/serial_sub_pkg.sv
// Shared types and helpers for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Bit counter width; never narrower than one bit so WIDTH=1 still has a counter.
  function automatic int cnt_w(input int w);
    int c;
    c = $clog2(w);
    return (c < 1) ? 1 : c;
  endfunction

endpackage

// File: rtl/full_subtractor.sv
// Single-bit full subtractor cell: diff = a - b - bin, bout = borrow out.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Pure combinational cell.
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor, LSB first, WIDTH cycles per op.
// Optional signed overflow flag enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int CW = cnt_w(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] r_sh_q, r_sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
  logic             fs_diff, fs_bout;
  logic             accept, last;
  logic [WIDTH-1:0] r_next;
`ifdef SERIAL_SUB_OVF_EN
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             ovf_q, ovf_d;
`endif

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (brw_q),
    .diff (fs_diff),
    .bout (fs_bout)
  );

  // Accept in IDLE or DONE; RUN's final bit is the one where the counter hits WIDTH-1.
  always_comb begin
    accept = start && (state_q != ST_RUN);
    last   = (state_q == ST_RUN) && (cnt_q == CW'(WIDTH - 1));
    // Shift form avoids an empty slice when WIDTH is 1.
    r_next = (r_sh_q >> 1) | (WIDTH'(fs_diff) << (WIDTH - 1));
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept) state_d = ST_RUN;
      ST_RUN:  if (last)   state_d = ST_DONE;
      ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM outputs, decoded straight from the state register.
  always_comb begin
    busy = (state_q == ST_RUN);
    done = (state_q == ST_DONE);
  end

  // Datapath next-state: load on accept, shift while running, publish on the last bit.
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    r_sh_d = r_sh_q;
    cnt_d  = cnt_q;
    brw_d  = brw_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (accept) begin
      a_sh_d = a;
      b_sh_d = b;
      brw_d  = 1'b0;
      cnt_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end else if (state_q == ST_RUN) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      r_sh_d = r_next;
      brw_d  = fs_bout;
      cnt_d  = cnt_q + CW'(1);
      if (last) begin
        diff_d = r_next;
        bout_d = fs_bout;
        cnt_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
        // The last bit processed is the result MSB.
        ovf_d = (a_msb_q != b_msb_q) && (fs_diff != a_msb_q);
`endif
      end
    end
  end

  // Datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      r_sh_q <= '0;
      cnt_q  <= '0;
      brw_q  <= 1'b0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      r_sh_q <= r_sh_d;
      cnt_q  <= cnt_d;
      brw_q  <= brw_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign diff       = diff_q;
  assign borrow_out = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign overflow   = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         overflow;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow   (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One operation from an idle block: pulse start, count edges to done.
  task automatic run_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [W-1:0] dexp, input logic bexp, input logic oexp);
    int n;
    logic busy_ok;
    a = av; b = bv; start = 1'b1;
    step();                       // E0
    start = 1'b0; a = ~av; b = ~bv; // inputs must not matter after accept
    n = 0; busy_ok = 1'b1;
    while (n < 40) begin
      if (!busy) busy_ok = 1'b0;
      step();
      n++;
      if (done) break;
    end
    chk({tag, " latency"}, 64'(n), 64'(W));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " diff"}, 64'(diff), 64'(dexp));
    chk({tag, " borrow"}, 64'(borrow_out), 64'(bexp));
`ifdef SERIAL_SUB_OVF_EN
    chk({tag, " ovf"}, 64'(overflow), 64'(oexp));
`else
    if (oexp) begin end
`endif
    step();
    chk({tag, " done_fall"}, 64'(done), 64'd0);
    chk({tag, " idle"}, 64'(busy), 64'd0);
    chk({tag, " hold"}, 64'(diff), 64'(dexp));
  endtask

  initial begin
    int ndone, last_done, first_done;

    // Reset state
    #2;
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst diff", 64'(diff), 64'd0);
    chk("rst borrow", 64'(borrow_out), 64'd0);
    step(); step();
    rst_n = 1'b1;
    step();

    // Main function, hand-computed vectors
    run_op("05-03", 8'h05, 8'h03, 8'h02, 1'b0, 1'b0);
    run_op("03-05", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0);
    run_op("00-00", 8'h00, 8'h00, 8'h00, 1'b0, 1'b0);
    run_op("80-01", 8'h80, 8'h01, 8'h7F, 1'b0, 1'b1);
    run_op("00-80", 8'h00, 8'h80, 8'h80, 1'b1, 1'b1);

    // Reset at RUN cycle 4 aborts; outputs go to reset values at once
    a = 8'h33; b = 8'h11; start = 1'b1;
    step();
    start = 1'b0;
    step(); step(); step(); step();
    chk("abort running", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort diff", 64'(diff), 64'd0);
    chk("abort borrow", 64'(borrow_out), 64'd0);
`ifdef SERIAL_SUB_OVF_EN
    chk("abort ovf", 64'(overflow), 64'd0);
`endif
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    run_op("09-04", 8'h09, 8'h04, 8'h05, 1'b0, 1'b0);

    // Start during RUN is ignored
    a = 8'h10; b = 8'h01; start = 1'b1;
    step();                     // E0
    start = 1'b0;
    step(); step();             // E1, E2
    a = 8'hFF; b = 8'hFF; start = 1'b1;
    step();                     // E3 (ignored)
    start = 1'b0;
    ndone = 0; first_done = -1;
    for (int i = 4; i < 24; i++) begin
      step();
      if (done) begin
        ndone++;
        if (first_done < 0) first_done = i;
      end
    end
    chk("ign ndone", 64'(ndone), 64'd1);
    chk("ign when", 64'(first_done), 64'(W));
    chk("ign diff", 64'(diff), 64'h0F);
    chk("ign borrow", 64'(borrow_out), 64'd0);

    // Start held high: back-to-back, one op per W+1 cycles
    a = 8'h20; b = 8'h10; start = 1'b1;
    step();                     // E0
    ndone = 0; last_done = -1; first_done = -1;
    for (int i = 1; i <= 3 * (W + 1); i++) begin
      step();
      chk("b2b busy", 64'(busy), 64'(!done));
      if (done) begin
        ndone++;
        chk("b2b diff", 64'(diff), 64'h10);
        if (last_done >= 0) chk("b2b gap", 64'(i - last_done), 64'(W + 1));
        else first_done = i;
        last_done = i;
      end
    end
    start = 1'b0;
    chk("b2b first", 64'(first_done), 64'(W));
    chk("b2b count", 64'(ndone), 64'd3);
    for (int i = 0; i < 2 * W; i++) step();
    chk("b2b drained", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
